// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, clog2 helper and the baud divider macro.
// Used by uart_rx_buffered and intended for the future uart_tx_buffered.
`define UART_DIV(f, b, o) ((((f) / ((b) * (o))) < 1) ? 1 : ((f) / ((b) * (o))))

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side read port of the buffered UART receiver.
interface uart_rx_buffered_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned AW        = 4
);
  logic                 RD_REQ;
  logic [DATA_BITS-1:0] D;
  logic                 RD_VALID;
  logic                 EMPTY_SIG;
  logic                 FULL_SIG;
  logic [AW:0]          LEVEL;

  modport master (output RD_REQ, input D, RD_VALID, EMPTY_SIG, FULL_SIG, LEVEL);
  modport slave  (input RD_REQ, output D, RD_VALID, EMPTY_SIG, FULL_SIG, LEVEL);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read data, one-cycle read-valid pulse and registered flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           q,
  output logic                       valid,
  output logic                       empty,
  output logic                       full,
  output logic [clog2(DEPTH):0]      level
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
  logic             push_ok_c, pop_ok_c;

  // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
  always_comb begin
    pop_ok_c  = pop & ~empty;
    push_ok_c = push & (~full | pop_ok_c);
    wptr_n    = wptr + (AW+1)'(push_ok_c);
    rptr_n    = rptr + (AW+1)'(pop_ok_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      level <= '0;
      q     <= '0;
      valid <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      empty <= (wptr_n == rptr_n);
      full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      level <= wptr_n - rptr_n;
      valid <= pop_ok_c;
      if (pop_ok_c) q <= mem[rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver feeding a synchronous receive FIFO, with sticky error flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic SYS_CLK,
  input  logic RST_N,
  input  logic RX,
  input  logic CLR_ERR,
  output logic FRAME_ERR,
  output logic PAR_ERR,
  output logic OVERRUN,
  uart_rx_buffered_if.slave rd
);

  localparam int unsigned DIV = `UART_DIV(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TW  = (DIV > 1) ? clog2(DIV) : 1;
  localparam int unsigned SW  = clog2(OVERSAMPLE);
  localparam int unsigned BW  = clog2(DATA_BITS);

  uart_state_e          state, state_nxt;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_q;
  logic                 tick_c, mid_c, full_bit_c;
  logic                 restart_c, samp_clr_c, shift_c, bit_inc_c, bit_clr_c;
  logic                 push_c, frame_set_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_sample_c, par_mismatch_c;
`endif

  always_comb begin
    tick_c     = (tick_cnt == TW'(DIV - 1));
    mid_c      = tick_c && (samp_cnt == SW'(OVERSAMPLE/2 - 1));
    full_bit_c = tick_c && (samp_cnt == SW'(OVERSAMPLE - 1));
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes; stop sampling returns to IDLE at mid-stop.
  always_comb begin
    state_nxt   = state;
    restart_c   = 1'b0;
    samp_clr_c  = 1'b0;
    shift_c     = 1'b0;
    bit_inc_c   = 1'b0;
    bit_clr_c   = 1'b0;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample_c = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_sync) begin
          restart_c = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (mid_c) begin
          samp_clr_c = 1'b1;
          bit_clr_c  = 1'b1;
          state_nxt  = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_bit_c) begin
          samp_clr_c = 1'b1;
          shift_c    = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_clr_c = 1'b1;
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_inc_c = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_bit_c) begin
          samp_clr_c   = 1'b1;
          par_sample_c = 1'b1;
          state_nxt    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (full_bit_c) begin
          samp_clr_c = 1'b1;
          if (!rx_sync) begin
            frame_set_c = 1'b1;
            state_nxt   = ST_BREAK;
          end else if (bit_cnt == BW'(STOP_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            push_c    = ~par_bad;
`else
            push_c    = 1'b1;
`endif
            state_nxt = ST_IDLE;
          end else begin
            bit_inc_c = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      tick_cnt <= (restart_c || tick_c) ? '0 : tick_cnt + TW'(1);
      if (restart_c || samp_clr_c) samp_cnt <= '0;
      else if (tick_c)             samp_cnt <= samp_cnt + SW'(1);
      if (bit_clr_c)      bit_cnt <= '0;
      else if (bit_inc_c) bit_cnt <= bit_cnt + BW'(1);
      if (shift_c) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
      push_q <= push_c;
      // Clear wins over a same-cycle set.
      if (CLR_ERR) begin
        FRAME_ERR <= 1'b0;
        OVERRUN   <= 1'b0;
      end else begin
        if (frame_set_c) FRAME_ERR <= 1'b1;
        if (push_q && rd.FULL_SIG && !rd.RD_REQ) OVERRUN <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_comb par_mismatch_c = rx_sync ^ (^shreg) ^ PARITY_ODD;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_bad <= 1'b0;
      PAR_ERR <= 1'b0;
    end else begin
      if (restart_c)         par_bad <= 1'b0;
      else if (par_sample_c) par_bad <= par_mismatch_c;
      if (CLR_ERR)                              PAR_ERR <= 1'b0;
      else if (par_sample_c && par_mismatch_c) PAR_ERR <= 1'b1;
    end
  end
`else
  assign PAR_ERR = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (SYS_CLK),
    .rst_n (RST_N),
    .push  (push_q),
    .wdata (shreg),
    .pop   (rd.RD_REQ),
    .q     (rd.D),
    .valid (rd.RD_VALID),
    .empty (rd.EMPTY_SIG),
    .full  (rd.FULL_SIG),
    .level (rd.LEVEL)
  );

endmodule
